// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg -- shared definitions for the instruction-memory loader.
//
// Contents:
//   IMEM_DEPTH      number of 32-bit words in the instruction memory
//   BYTES_PER_WORD  bytes assembled into one instruction word
//   WORD_W, BCNT_W  derived word width and byte-counter width
//   ST_*            loader FSM state encoding (ST_CSUM is only reachable when
//                   the loader is built with IMEM_LOADER_CHECKSUM_EN)
//   byte_beat_t     one accepted byte travelling with its valid flag
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int IMEM_DEPTH     = 512;
   localparam int BYTES_PER_WORD = 4;
   localparam int WORD_W         = 8 * BYTES_PER_WORD;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_RECV  = 3'd1;
   localparam state_t ST_WRITE = 3'd2;
   localparam state_t ST_FIN   = 3'd3;
   localparam state_t ST_CSUM  = 3'd4;

   typedef struct packed {
      logic       vld;
      logic [7:0] data;
   } byte_beat_t;

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if -- command, byte-stream and memory-write bundle of the loader.
//
// Signals:
//   load_start, load_len     load command (host -> loader)
//   byte_valid, byte_data    incoming byte stream (host -> loader)
//   byte_ready               loader accepts a byte this cycle
//   imem_addr/din/wea        instruction-memory write port (loader -> memory)
//   busy, cpu_hold, done     load status (cpu_hold mirrors busy)
//   err                      checksum mismatch flag
//
// Modports:
//   slave   loader side (receives command and bytes, drives memory/status)
//   master  host side   (drives command and bytes, observes the rest)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 10
);

   logic              load_start;
   logic [LEN_W-1:0]  load_len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_din;
   logic              imem_wea;
   logic              busy;
   logic              cpu_hold;
   logic              done;
   logic              err;

   modport slave (
      input  load_start, load_len, byte_valid, byte_data,
      output byte_ready, imem_addr, imem_din, imem_wea,
             busy, cpu_hold, done, err
   );

   modport master (
      output load_start, load_len, byte_valid, byte_data,
      input  byte_ready, imem_addr, imem_din, imem_wea,
             busy, cpu_hold, done, err
   );

endinterface

// File: rtl/imem_word_packer.sv
// -----------------------------------------------------------------------------
// imem_word_packer -- little-endian byte-to-word assembler.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        restart byte counting at a word boundary (new load)
//   beat       accepted byte and its valid flag
//   word_done  the byte presented this cycle completes a word
//   word       assembled word; valid the cycle after word_done
//
// Bytes shift in from the top, so after four accepted bytes the first one
// sits in [7:0] and the fourth in [31:24].
// -----------------------------------------------------------------------------
module imem_word_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  byte_beat_t        beat,
   output logic              word_done,
   output logic [WORD_W-1:0] word
);

   logic [BCNT_W-1:0] cnt_p0;
   logic [WORD_W-1:0] word_p0;

   assign word_done = beat.vld && (cnt_p0 == BCNT_W'(BYTES_PER_WORD - 1));
   assign word      = word_p0;

   // ---- p0: byte count and shift register ----
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_p0 <= '0;
      end else if (beat.vld) begin
         cnt_p0 <= word_done ? '0 : cnt_p0 + BCNT_W'(1);
      end
   end

   // The word register is cleared on reset so the memory data bus idles at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_p0 <= '0;
      end else if (beat.vld) begin
         word_p0 <= {beat.data, word_p0[WORD_W-1:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader -- loads a little-endian byte stream into instruction memory
// while holding the CPU in reset.
//
// Parameters:
//   ADDR_W  instruction-memory word-address width (default 9 -> 512 words)
//   LEN_W   width of the requested load length
//
// Ports:
//   clk     single clock, rising edge
//   rst     synchronous active-high reset
//   bus     imem_loader_if.slave: load command, byte stream, memory write
//           port, busy/cpu_hold/done status and err
//
// Optional build macro:
//   IMEM_LOADER_CHECKSUM_EN  after the last word, one extra byte is taken and
//                            compared with the XOR of all data bytes; a
//                            mismatch sets err (sticky until the next
//                            load_start or rst). Undefined: err is tied to 0.
//
// Flow: IDLE -> RECV (collect 4 bytes) -> WRITE (one-cycle wea) -> RECV ...
//       -> [CSUM] -> FIN (done pulse) -> IDLE. A zero-length load goes
//       straight from IDLE to FIN.
// -----------------------------------------------------------------------------
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 10
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   // Lengths beyond the memory depth saturate so the address never wraps.
   function automatic logic [ADDR_W:0] clamp_len(input logic [LEN_W-1:0] len);
      if (32'(len) > IMEM_DEPTH) begin
         clamp_len = (ADDR_W+1)'(IMEM_DEPTH);
      end else begin
         clamp_len = (ADDR_W+1)'(len);
      end
   endfunction

   state_t              state;
   logic [ADDR_W-1:0]   widx;
   logic [ADDR_W:0]     len_q;
   logic                accept;
   logic                last_word;
   logic                start_ok;
   byte_beat_t          beat;
   logic                word_done;
   logic [WORD_W-1:0]   word;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_p0;
   logic                err_q;
`endif

   assign accept    = bus.byte_valid && bus.byte_ready;
   assign start_ok  = (state == ST_IDLE) && bus.load_start;
   // widx is not advanced past the last word, so compare against widx + 1.
   assign last_word = (({1'b0, widx} + (ADDR_W+1)'(1)) == len_q);

   // Only data bytes reach the packer; the checksum byte bypasses it.
   assign beat.vld  = accept && (state == ST_RECV);
   assign beat.data = bus.byte_data;

   imem_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_ok),
      .beat      (beat),
      .word_done (word_done),
      .word      (word)
   );

   // ---- FSM and word index ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         widx  <= '0;
         len_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         err_q <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.load_start) begin
                  widx  <= '0;
                  len_q <= clamp_len(bus.load_len);
`ifdef IMEM_LOADER_CHECKSUM_EN
                  err_q   <= 1'b0;
                  csum_p0 <= '0;
`endif
                  state <= (bus.load_len == '0) ? ST_FIN : ST_RECV;
               end
            end
            ST_RECV: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               if (accept) begin
                  csum_p0 <= csum_p0 ^ bus.byte_data;
               end
`endif
               if (word_done) begin
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state <= ST_CSUM;
`else
                  state <= ST_FIN;
`endif
               end else begin
                  widx  <= widx + ADDR_W'(1);
                  state <= ST_RECV;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (accept) begin
                  err_q <= (bus.byte_data != csum_p0);
                  state <= ST_FIN;
               end
            end
`endif
            ST_FIN: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---- outputs, decoded from registered state ----
   assign bus.imem_wea  = (state == ST_WRITE);
   assign bus.imem_addr = widx;
   assign bus.imem_din  = word;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.cpu_hold  = bus.busy;
   assign bus.done      = (state == ST_FIN);

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign bus.byte_ready = (state == ST_RECV) || (state == ST_CSUM);
   assign bus.err        = err_q;
`else
   assign bus.byte_ready = (state == ST_RECV);
   assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader -- self-checking bench for imem_loader.
//
// A transaction-level model predicts, every cycle, whether a write, a done
// pulse, busy and byte_ready must be present, from counts of accepted bytes
// and written words. Directed loads add literal expectations on the logged
// writes. Build with IMEM_LOADER_CHECKSUM_EN to include the checksum cases.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   import imem_pkg::*;

   localparam int ADDR_W = 9;
   localparam int LEN_W  = 10;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   // model expectations for the current cycle
   bit                armed = 1'b0;
   bit                e_wea, e_busy, e_done, e_ready, e_err;
   logic [ADDR_W-1:0] e_addr;
   logic [31:0]       e_din;
   // model bookkeeping
   int                m_len, m_words, m_bytes;
   logic [31:0]       m_cur;
   logic [7:0]        m_xor;
   bit                m_csum_phase;
   // logs of DUT activity
   int                wr_cnt = 0, done_cnt = 0, busy_cycles = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [31:0]       last_din = '0;

   always @(negedge clk) begin : compare
      bit                n_wea, n_busy, n_done, n_ready, n_err;
      logic [ADDR_W-1:0] n_addr;
      logic [31:0]       n_din;
      if (armed) begin
         chk("imem_wea",   32'(bus.imem_wea),   32'(e_wea));
         chk("busy",       32'(bus.busy),       32'(e_busy));
         chk("cpu_hold",   32'(bus.cpu_hold),   32'(e_busy));
         chk("done",       32'(bus.done),       32'(e_done));
         chk("byte_ready", 32'(bus.byte_ready), 32'(e_ready));
         chk("err",        32'(bus.err),        32'(e_err));
         if (e_wea) begin
            chk("imem_addr", 32'(bus.imem_addr), 32'(e_addr));
            chk("imem_din",  bus.imem_din,       e_din);
         end
      end
      if (bus.imem_wea === 1'b1) begin
         wr_cnt++;
         last_addr = bus.imem_addr;
         last_din  = bus.imem_din;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) busy_cycles++;

      n_wea  = 1'b0;
      n_done = 1'b0;
      n_busy = e_busy;
      n_err  = e_err;
      n_addr = e_addr;
      n_din  = e_din;
      if (rst) begin
         armed        = 1'b1;
         n_busy       = 1'b0;
         n_err        = 1'b0;
         m_csum_phase = 1'b0;
      end else if (!e_busy) begin
         if (bus.load_start) begin
            m_len        = (int'(bus.load_len) > IMEM_DEPTH) ? IMEM_DEPTH : int'(bus.load_len);
            m_words      = 0;
            m_bytes      = 0;
            m_cur        = '0;
            m_xor        = '0;
            m_csum_phase = 1'b0;
            n_err        = 1'b0;
            n_busy       = 1'b1;
            n_done       = (m_len == 0);
         end
      end else if (e_done) begin
         n_busy = 1'b0;
      end else if (e_wea) begin
         m_words++;
         if (m_words == m_len) begin
            if (CSUM_EN) m_csum_phase = 1'b1;
            else n_done = 1'b1;
         end
      end else if (bus.byte_valid && e_ready) begin
         if (m_csum_phase) begin
            n_err  = (bus.byte_data != m_xor);
            n_done = 1'b1;
         end else begin
            m_cur = m_cur | (32'(bus.byte_data) << (8 * (m_bytes % 4)));
            m_xor = m_xor ^ bus.byte_data;
            m_bytes++;
            if (m_bytes % 4 == 0) begin
               n_wea  = 1'b1;
               n_addr = ADDR_W'(m_words);
               n_din  = m_cur;
               m_cur  = '0;
            end
         end
      end
      n_ready = n_busy && !n_wea && !n_done;
      e_wea   = n_wea;
      e_busy  = n_busy;
      e_done  = n_done;
      e_ready = n_ready;
      e_err   = n_err;
      e_addr  = n_addr;
      e_din   = n_din;
   end

   logic [7:0] tb_xor;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_load(input int len);
      tb_xor         = '0;
      bus.load_start = 1'b1;
      bus.load_len   = LEN_W'(len);
      @(posedge clk);
      #1;
      bus.load_start = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 right after the transfer edge.
   task automatic send_byte(input logic [7:0] b);
      int t;
      t              = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      @(negedge clk);
      while (bus.byte_ready !== 1'b1 && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (bus.byte_ready !== 1'b1) begin
         n_checks++;
         $display("FAIL send_byte_timeout: byte_ready=%b, want 1", bus.byte_ready);
      end
      tb_xor = tb_xor ^ b;
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_csum_if_enabled();
      if (CSUM_EN) send_byte(tb_xor);
   endtask

   task automatic wait_done(input int d0, input int bound);
      int t;
      t = 0;
      while (done_cnt == d0 && t < bound) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (done_cnt == d0) begin
         n_checks++;
         $display("FAIL done_timeout: no done pulse within %0d cycles, want one", bound);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w0, d0, b0;
      bus.load_start = 1'b0;
      bus.load_len   = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      tb_xor         = '0;
      rst            = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      chk("rst_wea",   32'(bus.imem_wea),   0);
      chk("rst_busy",  32'(bus.busy),       0);
      chk("rst_hold",  32'(bus.cpu_hold),   0);
      chk("rst_done",  32'(bus.done),       0);
      chk("rst_err",   32'(bus.err),        0);
      chk("rst_ready", 32'(bus.byte_ready), 0);
      chk("rst_addr",  32'(bus.imem_addr),  0);
      chk("rst_din",   bus.imem_din,        0);
      idle(2);

      // single word
      w0 = wr_cnt; d0 = done_cnt;
      start_load(1);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'hA0); send_byte(8'hE3);
      send_csum_if_enabled();
      wait_done(d0, 20);
      chk("t1_writes", 32'(wr_cnt - w0), 1);
      chk("t1_addr",   32'(last_addr),   0);
      chk("t1_din",    last_din,         32'hE3A00013);
      chk("t1_done",   32'(done_cnt - d0), 1);
      chk("t1_err",    32'(bus.err),     0);
      idle(2);
      chk("t1_idle_busy", 32'(bus.busy), 0);

      // three words, valid every other cycle, load_start held high meanwhile
      w0 = wr_cnt; d0 = done_cnt;
      start_load(3);
      bus.load_start = 1'b1;
      bus.load_len   = '0;
      for (int i = 0; i < 12; i++) begin
         send_byte(8'(8'h10 + i));
         idle(1);
      end
      bus.load_start = 1'b0;
      send_csum_if_enabled();
      wait_done(d0, 20);
      chk("t2_writes", 32'(wr_cnt - w0), 3);
      chk("t2_addr",   32'(last_addr),   2);
      chk("t2_din",    last_din,         32'h1B1A1918);
      chk("t2_done",   32'(done_cnt - d0), 1);
      idle(2);

      // oversize length clamps to the memory depth
      w0 = wr_cnt; d0 = done_cnt;
      start_load(600);
      for (int i = 0; i < 4 * IMEM_DEPTH; i++) send_byte(8'(i * 7 + 3));
      send_csum_if_enabled();
      wait_done(d0, 20);
      chk("t3_writes", 32'(wr_cnt - w0), 512);
      chk("t3_addr",   32'(last_addr),   511);
      chk("t3_din",    last_din,         32'hFCF5EEE7);
      chk("t3_done",   32'(done_cnt - d0), 1);
      idle(2);

      // zero length
      w0 = wr_cnt; d0 = done_cnt; b0 = busy_cycles;
      start_load(0);
      wait_done(d0, 10);
      idle(2);
      chk("t4_writes", 32'(wr_cnt - w0), 0);
      chk("t4_done",   32'(done_cnt - d0), 1);
      chk("t4_busy_cycles", 32'(busy_cycles - b0), 1);

      // reset in the middle of the second word
      w0 = wr_cnt; d0 = done_cnt;
      start_load(4);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("t5_writes", 32'(wr_cnt - w0), 1);
      chk("t5_addr",   32'(last_addr),   0);
      chk("t5_din",    last_din,         32'h44332211);
      chk("t5_wea",    32'(bus.imem_wea),   0);
      chk("t5_busy",   32'(bus.busy),       0);
      chk("t5_hold",   32'(bus.cpu_hold),   0);
      chk("t5_done",   32'(bus.done),       0);
      chk("t5_err",    32'(bus.err),        0);
      chk("t5_ready",  32'(bus.byte_ready), 0);
      chk("t5_raddr",  32'(bus.imem_addr),  0);
      chk("t5_rdin",   bus.imem_din,        0);
      idle(12);
      chk("t5_no_more_writes", 32'(wr_cnt - w0), 1);
      chk("t5_no_done",        32'(done_cnt - d0), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // matching checksum
      d0 = done_cnt;
      start_load(1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0F);
      wait_done(d0, 20);
      chk("t6_din", last_din,     32'h08040201);
      chk("t6_err", 32'(bus.err), 0);
      idle(2);
      // mismatching checksum, then sticky until the next start
      d0 = done_cnt;
      start_load(1);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(8'h0E);
      wait_done(d0, 20);
      chk("t7_err",        32'(bus.err), 1);
      chk("t7_done",       32'(done_cnt - d0), 1);
      idle(3);
      chk("t7_err_sticky", 32'(bus.err), 1);
      d0 = done_cnt;
      start_load(0);
      wait_done(d0, 10);
      chk("t7_err_cleared", 32'(bus.err), 0);
      idle(2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
